ftsd_name_scroller: RTL
=======================

# ftsd_name_scroller

Sequencer for the four-digit 14-segment FTSD that displays the current song title as a scrolling marquee. It scans the four digits, computes which character index each digit shows, and queries the song-name character decoder through `value`/`song_sel`. It registers the returned 15-bit pattern together with the matching active-low digit enable. It sits between the song-selection logic (which supplies `song`/`pause`) and the FTSD pins.

## Interface
- `SCAN_DIV`, 20'd50000, clock cycles per digit slot (refresh tick period); must be ≥ 2
- `SCROLL_DIV`, 26'd25000000, clock cycles per one-character scroll step; must be ≥ 2
- `clk`  input  1  system clock, all state on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `song`  input  3  requested song number (0–5 valid; 6–7 pass through, decoder blanks them)
- `pause`  input  1  1 = freeze scroll position (scanning continues)
- `display_in`  input  15  segment pattern returned by the name decoder for (`value`, `song_sel`), combinational
- `value`  output  3  character index requested from decoder
- `song_sel`  output  3  latched song number presented to decoder
- `ftsd_ctl`  output  4  digit enables, active low; bit 3 = leftmost digit
- `ftsd_seg`  output  15  registered segment pattern, active low (all 1 = blank)

## Operation
- Character string is 8 positions long: indices 0–5 are the title ("SONG0n"), indices 6–7 decode to blank (gap between repetitions).
- State: `scan_cnt` (0..SCAN_DIV-1), `digit` (2 bit, 0 = leftmost), `scroll_cnt` (0..SCROLL_DIV-1), `offset` (3 bit), `song_sel` (3 bit).
- `value` = (`offset` + `digit`) mod 8, combinational from registers only (3-bit natural wrap).
- Scan: `scan_cnt` increments every cycle; at SCAN_DIV-1 it returns to 0 and `digit` increments mod 4 (3 → 0).
- Scroll: when `pause` = 0, `scroll_cnt` increments; at SCROLL_DIV-1 it returns to 0 and `offset` increments mod 8 (7 → 0). When `pause` = 1, `scroll_cnt` and `offset` hold.
- Song change: every cycle in which `song` ≠ `song_sel`, the block loads `song_sel` ← `song`, `offset` ← 0 and `scroll_cnt` ← 0. This takes priority over a coincident scroll tick and over `pause`. Scan state is unaffected.
- Output register, every cycle: `ftsd_seg` ← `display_in`; `ftsd_ctl` ← all ones except bit (3 − `digit`) = 0.
- Exactly one `ftsd_ctl` bit is low at any time after the first post-reset edge.

## Timing
- Reset (async assert, any cycle): `scan_cnt` = 0, `digit` = 0, `scroll_cnt` = 0, `offset` = 0, `song_sel` = 0, `value` = 0, `ftsd_ctl` = 4'b1111, `ftsd_seg` = 15'h7FFF.
- First edge after reset release: `ftsd_ctl` = 4'b0111, `ftsd_seg` = pattern for index 0 of song 0.
- `ftsd_seg`/`ftsd_ctl` lag `digit`/`offset`/`song_sel` by exactly 1 cycle. The pair is always mutually consistent (same-edge update).
- Each digit is driven for exactly SCAN_DIV cycles. The full frame is 4·SCAN_DIV cycles.
- Offset step period is exactly SCROLL_DIV cycles of `pause` = 0. Pause cycles are not counted.
- `song` change is seen on the next edge. The new name appears on `ftsd_seg` 2 edges after `song` changes.
- `song` toggling back before it is sampled is not detected; no change effect occurs.

## Test plan
- Reset mid-operation (`digit` = 2, `offset` = 5) → all outputs return to reset values asynchronously, before the next clock edge; after release `ftsd_ctl` sequence is 0111, 1011, 1101, 1110, 0111 at SCAN_DIV cycle spacing.
- SCAN_DIV = 4, SCROLL_DIV = 32, song = 0, pause = 0 → `offset` steps 0→1→…→7→0 every 32 cycles; with `offset` = 6, digits show indices 6, 7, 0, 1 (blank, blank, S, O).
- `offset` = 7, `digit` = 3 → `value` = 2 (wrap), `ftsd_seg` = N pattern, `ftsd_ctl` = 1110 one cycle later.
- `pause` = 1 held for 100 cycles at `scroll_cnt` = 30 → `offset` and `scroll_cnt` frozen while `digit` keeps cycling; after release, `offset` increments 2 cycles later.
- With `offset` = 4, set `song` 0→3 on a cycle where `scroll_cnt` = SCROLL_DIV-1 → next edge: `song_sel` = 3, `offset` = 0 (not 5), `scroll_cnt` = 0; the index-5 character later shows the digit-3 pattern.
- `song` = 7 → `song_sel` = 7, all `ftsd_seg` = 15'h7FFF, while `ftsd_ctl` continues scanning normally.

Source files
------------

// File: rtl/ftsd_name_scroller.sv
// Scrolling song-title marquee sequencer for a four-digit 14-segment display.
// Scans digits, asks the name decoder for each digit's character, registers segments and enables.
module ftsd_name_scroller #(
    parameter logic [19:0] SCAN_DIV   = 20'd50000,
    parameter logic [25:0] SCROLL_DIV = 26'd25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  song,
    input  logic        pause,
    input  logic [14:0] display_in,
    output logic [2:0]  value,
    output logic [2:0]  song_sel,
    output logic [3:0]  ftsd_ctl,
    output logic [14:0] ftsd_seg
);

    logic [19:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic [25:0] scroll_cnt_q, scroll_cnt_d;
    logic [2:0]  offset_q, offset_d;
    logic [2:0]  song_sel_q, song_sel_d;
    logic [3:0]  ftsd_ctl_q, ftsd_ctl_d;
    logic [14:0] ftsd_seg_q, ftsd_seg_d;

    // 3-bit add wraps naturally across the 8-position string
    assign value    = offset_q + {1'b0, digit_q};
    assign song_sel = song_sel_q;
    assign ftsd_ctl = ftsd_ctl_q;
    assign ftsd_seg = ftsd_seg_q;

    always_comb begin
        scan_cnt_d   = scan_cnt_q + 20'd1;
        digit_d      = digit_q;
        scroll_cnt_d = scroll_cnt_q;
        offset_d     = offset_q;
        song_sel_d   = song_sel_q;

        if (scan_cnt_q == SCAN_DIV - 20'd1) begin
            scan_cnt_d = 20'd0;
            digit_d    = digit_q + 2'd1;
        end

        // A new song restarts the title from its first character, even while paused
        if (song != song_sel_q) begin
            song_sel_d   = song;
            offset_d     = 3'd0;
            scroll_cnt_d = 26'd0;
        end else if (!pause) begin
            if (scroll_cnt_q == SCROLL_DIV - 26'd1) begin
                scroll_cnt_d = 26'd0;
                offset_d     = offset_q + 3'd1;
            end else begin
                scroll_cnt_d = scroll_cnt_q + 26'd1;
            end
        end

        // Enable and pattern both reflect the current digit, so they stay paired
        ftsd_ctl_d = ~(4'b1000 >> digit_q);
        ftsd_seg_d = display_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q   <= 20'd0;
            digit_q      <= 2'd0;
            scroll_cnt_q <= 26'd0;
            offset_q     <= 3'd0;
            song_sel_q   <= 3'd0;
            ftsd_ctl_q   <= 4'b1111;
            ftsd_seg_q   <= 15'h7FFF;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            digit_q      <= digit_d;
            scroll_cnt_q <= scroll_cnt_d;
            offset_q     <= offset_d;
            song_sel_q   <= song_sel_d;
            ftsd_ctl_q   <= ftsd_ctl_d;
            ftsd_seg_q   <= ftsd_seg_d;
        end
    end

endmodule
